mem4x4_ctrl: RTL and testbench

//  Sequencer and 2-port round-robin arbiter for the memory4x4 array (4 words x 4 bits,

---
 rtl/mem4x4_pkg.sv | 21 ++
 rtl/mem4x4_ctrl_rr_arb2.sv | 42 ++++
 rtl/mem4x4_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mem4x4_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem4x4_pkg.sv
// Shared types for the memory4x4 controller: sequencer states, default geometry
// and the latched command record.
package mem4x4_pkg;

  localparam int MEM_AW = 2;
  localparam int MEM_DW = 4;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] din;
  } cmd_t;

endpackage

// File: rtl/mem4x4_ctrl_rr_arb2.sv
// Two-input round-robin arbiter. gnt is combinational from req and the
// last-winner register; the register only moves when the owner says advance.
module rr_arb2
  import mem4x4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       rr_last
);

  logic rr_last_q;
  logic rr_last_d;

  always_comb begin
    gnt       = 2'b00;
    rr_last_d = rr_last_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Contention goes to whoever did not win last time.
      2'b11:   gnt = rr_last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    if (advance && (gnt != 2'b00)) begin
      rr_last_d = gnt[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  assign rr_last = rr_last_q;

endmodule

// File: rtl/mem4x4_ctrl.sv
// Sequencer for a 4x4 memory: zero-fills the array after reset, then serves
// single-word reads/writes from two requesters, one access per three cycles.
module mem4x4_ctrl
  import mem4x4_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_din,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_din,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout,
  output logic          init_done,
  output logic          busy
);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } acc_cmd_t;

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  acc_cmd_t      cmd_q, cmd_d;
  acc_cmd_t      sel_cmd;
  logic [1:0]    ack_q, ack_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          mem_we_q, mem_we_d;
  logic          init_done_q, init_done_d;
  logic          busy_q, busy_d;

  logic [1:0]    gnt;
  logic          rr_last;
  logic          advance;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({r1_req, r0_req}),
    .advance (advance),
    .gnt     (gnt),
    .rr_last (rr_last)
  );

  assign sel_cmd = gnt[1] ? {r1_we, r1_addr, r1_din} : {r0_we, r0_addr, r0_din};

  // Output registers are loaded with the values belonging to the state being
  // entered, so the pins always describe the current state's activity.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    ack_d       = 2'b00;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_we_d    = 1'b0;
    init_done_d = init_done_q;
    busy_d      = 1'b1;
    advance     = 1'b0;
    case (state_q)
      INIT: begin
        if (cnt_q[AW]) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          mem_we_d   = 1'b1;
          mem_addr_d = cnt_q[AW-1:0];
          mem_din_d  = '0;
          cnt_d      = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        advance = 1'b1;
        if (gnt != 2'b00) begin
          state_d    = ACCESS;
          cmd_d      = sel_cmd;
          mem_we_d   = sel_cmd.we;
          mem_addr_d = sel_cmd.addr;
          mem_din_d  = sel_cmd.din;
        end else begin
          busy_d = 1'b0;
        end
      end
      ACCESS: begin
        // rr_last already holds the winner of this access.
        state_d        = DONE;
        mem_addr_d     = cmd_q.addr;
        mem_din_d      = cmd_q.din;
        ack_d[rr_last] = 1'b1;
        if (!cmd_q.we) begin
          if (rr_last) begin
            rdata1_d = mem_dout;
          end else begin
            rdata0_d = mem_dout;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      ack_q       <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    cmd_q <= cmd_d;
  end

  assign r0_ack    = ack_q[0];
  assign r1_ack    = ack_q[1];
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_we    = mem_we_q;
  assign init_done = init_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem4x4_ctrl.sv
// Bench for mem4x4_ctrl: stands in for the memory4x4 array and checks every
// handshake against a transaction-level shadow of the memory contents.
module tb_mem4x4_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       poison;
  logic       r0_req, r0_we, r0_ack;
  logic [1:0] r0_addr;
  logic [3:0] r0_din, r0_rdata;
  logic       r1_req, r1_we, r1_ack;
  logic [1:0] r1_addr;
  logic [3:0] r1_din, r1_rdata;
  logic [1:0] mem_addr;
  logic [3:0] mem_din, mem_dout;
  logic       mem_we, init_done, busy;

  logic [3:0] mem_arr [4];
  logic [3:0] shadow [4];
  logic [3:0] exp_rd [2];
  int         model_last;
  int         n_vec, n_err;

  mem4x4_ctrl dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_din(r0_din),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_din(r1_din),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // memory4x4 stand-in; poison fills it with junk so the clear sweep is visible
  always @(posedge clk) begin
    if (poison) begin
      for (int i = 0; i < 4; i++) mem_arr[i] <= 4'(15 - i);
    end else if (mem_we) begin
      mem_arr[mem_addr] <= mem_din;
    end
  end
  assign mem_dout = mem_arr[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) shadow[i] = 4'h0;
    exp_rd[0]  = 4'h0;
    exp_rd[1]  = 4'h0;
    model_last = 1;
  endtask

  task automatic do_init();
    r0_req = 1'b0; r1_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    model_clear();
  endtask

  task automatic raise(input int i);
    if (i == 0) begin
      r0_we = 1'($urandom_range(0, 1)); r0_addr = 2'($urandom_range(0, 3));
      r0_din = 4'($urandom_range(0, 15)); r0_req = 1'b1;
    end else begin
      r1_we = 1'($urandom_range(0, 1)); r1_addr = 2'($urandom_range(0, 3));
      r1_din = 4'($urandom_range(0, 15)); r1_req = 1'b1;
    end
  endtask

  // Runs pending requests to completion; reports ack cycle and rdata per requester.
  task automatic run_both(input int budget, output int t0, output int t1,
                          output logic [3:0] d0, output logic [3:0] d1);
    t0 = -1; t1 = -1; d0 = 4'h0; d1 = 4'h0;
    for (int c = 1; c <= budget && (r0_req || r1_req); c++) begin
      tick();
      if (r0_ack && r0_req) begin t0 = c; d0 = r0_rdata; r0_req = 1'b0; end
      if (r1_ack && r1_req) begin t1 = c; d1 = r1_rdata; r1_req = 1'b0; end
    end
    r0_req = 1'b0; r1_req = 1'b0;
  endtask

  task automatic test_reset();
    r0_req = 1'b0; r1_req = 1'b0;
    rst = 1'b1; poison = 1'b1;
    tick(); tick();
    rst = 1'b0; poison = 1'b0;
    n_vec++;
    if ({r0_ack, r1_ack, mem_we, init_done, busy} !== 5'b00001) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 00001", {r0_ack, r1_ack, mem_we, init_done, busy});
    end
    n_vec++;
    if ({mem_addr, mem_din, r0_rdata, r1_rdata} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_din, r0_rdata, r1_rdata});
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++;
      if (mem_we !== 1'b1 || mem_addr !== 2'(c) || mem_din !== 4'h0 ||
          r0_ack !== 1'b0 || r1_ack !== 1'b0 || init_done !== 1'b0) begin
        n_err++;
        $display("FAIL init_sweep c%0d: got we=%b addr=%0d din=%h ack=%b%b done=%b expected we=1 addr=%0d din=0 ack=00 done=0",
                 c, mem_we, mem_addr, mem_din, r1_ack, r0_ack, init_done, c);
      end
    end
    tick();
    n_vec++;
    if (init_done !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL init_end: got done=%b we=%b busy=%b expected 1 0 0", init_done, mem_we, busy);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (mem_arr[i] !== 4'h0) begin
        n_err++;
        $display("FAIL init_clear[%0d]: got %h expected 0", i, mem_arr[i]);
      end
    end
    model_clear();
  endtask

  task automatic test_write_read();
    int t0, t1;
    logic [3:0] d0, d1;
    r0_we = 1'b1; r0_addr = 2'd2; r0_din = 4'b1011; r0_req = 1'b1;
    run_both(10, t0, t1, d0, d1);
    tick();
    n_vec++;
    if (t0 != 2) begin n_err++; $display("FAIL wr_latency: got %0d expected 2", t0); end
    n_vec++;
    if (d0 !== exp_rd[0]) begin n_err++; $display("FAIL wr_rdata_hold: got %h expected %h", d0, exp_rd[0]); end
    shadow[2] = 4'b1011;
    model_last = 0;
    r0_we = 1'b0; r0_req = 1'b1;
    run_both(10, t0, t1, d0, d1);
    tick();
    n_vec++;
    if (t0 != 2) begin n_err++; $display("FAIL rd_latency: got %0d expected 2", t0); end
    n_vec++;
    if (d0 !== shadow[2]) begin n_err++; $display("FAIL raw_rdata: got %h expected %h", d0, shadow[2]); end
    exp_rd[0] = shadow[2];
  endtask

  task automatic test_collision();
    int t0, t1;
    logic [3:0] d0, d1;
    do_init();
    r0_we = 1'b1; r0_addr = 2'd0; r0_din = 4'b0111; r0_req = 1'b1;
    r1_we = 1'b0; r1_addr = 2'd0; r1_req = 1'b1;
    run_both(15, t0, t1, d0, d1);
    tick();
    shadow[0] = 4'b0111;
    n_vec++;
    if (t0 != 2 || t1 != 5) begin
      n_err++;
      $display("FAIL collide_order: got ack0@%0d ack1@%0d expected 2 and 5", t0, t1);
    end
    n_vec++;
    if (d1 !== shadow[0]) begin n_err++; $display("FAIL collide_rdata: got %h expected %h", d1, shadow[0]); end
    n_vec++;
    if (d0 !== exp_rd[0]) begin n_err++; $display("FAIL collide_wr_hold: got %h expected %h", d0, exp_rd[0]); end
    exp_rd[1] = shadow[0];
    model_last = 1;
  endtask

  // Random traffic against the shadow model. strict: both requesters always
  // pending, so grants must alternate and acks must be exactly 3 cycles apart.
  task automatic traffic(input int n_acks, input bit strict);
    int hold0, hold1, acks, prev_c;
    acks = 0; prev_c = -1;
    if (strict) begin
      raise(0); raise(1); hold0 = 0; hold1 = 0;
    end else begin
      hold0 = $urandom_range(1, 3); hold1 = $urandom_range(1, 3);
    end
    for (int c = 0; c < 600 && (acks < n_acks || r0_req || r1_req); c++) begin
      tick();
      if (!r0_req && hold0 > 0 && acks < n_acks) begin hold0--; if (hold0 == 0) raise(0); end
      if (!r1_req && hold1 > 0 && acks < n_acks) begin hold1--; if (hold1 == 0) raise(1); end
      n_vec++;
      if (r0_ack && r1_ack) begin n_err++; $display("FAIL dual_ack: got both acks expected at most one"); end
      for (int i = 0; i < 2; i++) begin
        logic ack_i, req_i, we_i;
        logic [1:0] a_i;
        logic [3:0] di_i, rd_i, rd_o;
        ack_i = (i == 0) ? r0_ack : r1_ack;
        req_i = (i == 0) ? r0_req : r1_req;
        we_i  = (i == 0) ? r0_we : r1_we;
        a_i   = (i == 0) ? r0_addr : r1_addr;
        di_i  = (i == 0) ? r0_din : r1_din;
        rd_i  = (i == 0) ? r0_rdata : r1_rdata;
        rd_o  = (i == 0) ? r1_rdata : r0_rdata;
        if (ack_i) begin
          n_vec++;
          if (!req_i) begin
            n_err++;
            $display("FAIL spurious_ack r%0d: got ack expected none", i);
          end else begin
            if (strict) begin
              n_vec++;
              if (i == model_last) begin n_err++; $display("FAIL rr_order: got r%0d expected r%0d", i, 1 - model_last); end
              if (prev_c >= 0) begin
                n_vec++;
                if (c - prev_c != 3) begin n_err++; $display("FAIL rr_spacing: got %0d expected 3", c - prev_c); end
              end
            end
            n_vec++;
            if (we_i) begin
              if (rd_i !== exp_rd[i]) begin n_err++; $display("FAIL wr_rdata_hold r%0d: got %h expected %h", i, rd_i, exp_rd[i]); end
              shadow[a_i] = di_i;
            end else begin
              if (rd_i !== shadow[a_i]) begin n_err++; $display("FAIL rd_data r%0d a%0d: got %h expected %h", i, a_i, rd_i, shadow[a_i]); end
              exp_rd[i] = shadow[a_i];
            end
            n_vec++;
            if (rd_o !== exp_rd[1 - i]) begin n_err++; $display("FAIL loser_rdata r%0d: got %h expected %h", 1 - i, rd_o, exp_rd[1 - i]); end
            model_last = i; prev_c = c; acks++;
            if (i == 0) begin r0_req = 1'b0; hold0 = strict ? 1 : $urandom_range(1, 4); end
            else        begin r1_req = 1'b0; hold1 = strict ? 1 : $urandom_range(1, 4); end
          end
        end
      end
    end
    n_vec++;
    if (acks < n_acks || r0_req || r1_req) begin
      n_err++;
      $display("FAIL traffic_timeout: got %0d acks expected %0d", acks, n_acks);
    end
    r0_req = 1'b0; r1_req = 1'b0;
    tick();
  endtask

  task automatic test_rr();
    traffic(12, 1'b1);
  endtask

  task automatic test_random();
    traffic(40, 1'b0);
  endtask

  task automatic test_reset_mid();
    int t0, t1;
    logic [3:0] d0, d1;
    r1_we = 1'b1; r1_addr = 2'd3; r1_din = 4'b1001; r1_req = 1'b1;
    tick();
    n_vec++;
    if (mem_we !== 1'b1 || mem_addr !== 2'd3 || mem_din !== 4'b1001) begin
      n_err++;
      $display("FAIL mid_access: got we=%b addr=%0d din=%h expected 1 3 9", mem_we, mem_addr, mem_din);
    end
    rst = 1'b1; r1_req = 1'b0;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({r1_ack, mem_we, mem_addr, init_done, busy} !== 6'b000001) begin
      n_err++;
      $display("FAIL mid_reset_out: got %b expected 000001", {r1_ack, mem_we, mem_addr, init_done, busy});
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++;
      if (r1_ack !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 2'(c)) begin
        n_err++;
        $display("FAIL mid_resweep c%0d: got ack=%b we=%b addr=%0d expected 0 1 %0d", c, r1_ack, mem_we, mem_addr, c);
      end
    end
    tick();
    model_clear();
    r0_we = 1'b0; r0_addr = 2'd3; r0_req = 1'b1;
    run_both(10, t0, t1, d0, d1);
    tick();
    n_vec++;
    if (t0 != 2 || d0 !== shadow[3]) begin
      n_err++;
      $display("FAIL mid_readback: got lat=%0d data=%h expected 2 %h", t0, d0, shadow[3]);
    end
    model_last = 0;
  endtask

  task automatic test_req_from_reset();
    int t;
    logic [3:0] d;
    t = -1; d = 4'hx;
    r1_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r0_we = 1'b0; r0_addr = 2'd1; r0_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (r0_ack) begin t = c; d = r0_rdata; r0_req = 1'b0; break; end
    end
    r0_req = 1'b0;
    tick();
    model_clear();
    n_vec++;
    if (t != 6) begin n_err++; $display("FAIL pending_lat: got cycle %0d expected 6", t); end
    n_vec++;
    if (d !== shadow[1]) begin n_err++; $display("FAIL pending_rdata: got %h expected %h", d, shadow[1]); end
    model_last = 0;
  endtask

  task automatic test_final_mem();
    tick();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (mem_arr[i] !== shadow[i]) begin
        n_err++;
        $display("FAIL final_mem[%0d]: got %h expected %h", i, mem_arr[i], shadow[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; poison = 1'b0;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = 2'd0; r0_din = 4'h0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = 2'd0; r1_din = 4'h0;
    n_vec = 0; n_err = 0;
    model_clear();
    test_reset();
    test_write_read();
    test_collision();
    test_rr();
    test_reset_mid();
    test_req_from_reset();
    test_random();
    test_final_mem();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
